// File: rtl/usbf_pd.sv
// USB function packet disassembler: decodes UTMI RX bytes into PID, token
// fields and data payload (CRC bytes held back and checked).
module usbf_pd #(
    parameter int unsigned MAX_PKT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_err,
    output logic [3:0]  pid,
    output logic        pid_valid,
    output logic        pid_cks_err,
    output logic [6:0]  token_fadr,
    output logic [3:0]  token_endp,
    output logic [10:0] frame_no,
    output logic        token_valid,
    output logic        crc5_err,
    output logic [7:0]  rx_data_st,
    output logic        rx_data_valid,
    output logic        rx_data_done,
    output logic        crc16_err,
    output logic [10:0] rx_size,
    output logic        seq_err
);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHK, S_DROP} state_t;

    state_t      state_q, state_d;
    logic        rx_active_r_q, rx_active_r_d;
    logic [3:0]  pid_q, pid_d;
    logic        pid_valid_q, pid_valid_d, pid_cks_err_q, pid_cks_err_d;
    logic [6:0]  fadr_q, fadr_d;
    logic [3:0]  endp_q, endp_d;
    logic [10:0] frame_no_q, frame_no_d;
    logic        token_valid_q, token_valid_d, crc5_err_q, crc5_err_d;
    logic [7:0]  data_st_q, data_st_d;
    logic        data_valid_q, data_valid_d, data_done_q, data_done_d;
    logic        crc16_err_q, crc16_err_d, seq_err_q, seq_err_d;
    logic [10:0] size_q, size_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [1:0]  tok_cnt_q, tok_cnt_d, hcnt_q, hcnt_d;
    logic [7:0]  hold0_q, hold0_d, hold1_q, hold1_d;
    logic        was_data_q, was_data_d;

    // Scratch values: state after absorbing this cycle's byte
    logic [4:0]  crc5_n;
    logic [15:0] crc16_n;
    logic [1:0]  cnt_n;
    logic        over;

    // CRC5 x^5+x^2+1, one byte LSB first
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
        logic [4:0] r;
        logic       fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[4] ^ b[3'(i)];
            r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return r;
    endfunction

    // CRC16 x^16+x^15+x^2+1, din processed MSB first
    function automatic logic [15:0] usbf_crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[15] ^ d[3'(7 - i)];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) r[3'(i)] = b[3'(7 - i)];
        return r;
    endfunction

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        rx_active_r_d = rx_active;
        pid_d         = pid_q;
        pid_valid_d   = 1'b0;
        pid_cks_err_d = 1'b0;
        fadr_d        = fadr_q;
        endp_d        = endp_q;
        frame_no_d    = frame_no_q;
        token_valid_d = 1'b0;
        crc5_err_d    = 1'b0;
        data_st_d     = data_st_q;
        data_valid_d  = 1'b0;
        data_done_d   = 1'b0;
        crc16_err_d   = 1'b0;
        seq_err_d     = 1'b0;
        size_d        = size_q;
        crc5_d        = crc5_q;
        crc16_d       = crc16_q;
        tok_cnt_d     = tok_cnt_q;
        hcnt_d        = hcnt_q;
        hold0_d       = hold0_q;
        hold1_d       = hold1_q;
        was_data_d    = was_data_q;
        crc5_n        = crc5_q;
        crc16_n       = crc16_q;
        cnt_n         = '0;
        over          = 1'b0;

        case (state_q)
            S_IDLE: begin
                was_data_d = 1'b0;
                if (rx_active && !rx_active_r_q) state_d = S_PID;
            end
            S_PID: begin
                if (rx_err) begin
                    seq_err_d = 1'b1;
                    state_d   = S_DROP;
                end else if (rx_valid) begin
                    if (rx_data[7:4] != ~rx_data[3:0]) begin
                        pid_cks_err_d = 1'b1;
                        state_d       = S_DROP;
                    end else begin
                        pid_d       = rx_data[3:0];
                        pid_valid_d = 1'b1;
                        case (rx_data[3:0])
                            4'h1, 4'h9, 4'hd, 4'h5, 4'h4: begin
                                state_d   = S_TOKEN;
                                tok_cnt_d = '0;
                                crc5_d    = '1;
                            end
                            4'h3, 4'hb, 4'h7, 4'hf: begin
                                state_d    = S_DATA;
                                crc16_d    = '1;
                                hcnt_d     = '0;
                                size_d     = '0;
                                was_data_d = 1'b1;
                            end
                            4'h2, 4'ha, 4'he, 4'h6: state_d = S_HSHK;
                            default:                state_d = S_DROP;
                        endcase
                    end
                end else if (!rx_active) begin
                    state_d = S_IDLE;
                end
            end
            S_TOKEN: begin
                if (rx_err) begin
                    seq_err_d = 1'b1;
                    state_d   = S_DROP;
                end else begin
                    // A byte arriving with the rx_active fall is absorbed before the end check
                    cnt_n = tok_cnt_q;
                    if (rx_valid) begin
                        if (tok_cnt_q == 2'd2) begin
                            over = 1'b1;
                        end else begin
                            crc5_n = crc5_byte(crc5_q, rx_data);
                            cnt_n  = tok_cnt_q + 2'd1;
                            if (tok_cnt_q == 2'd0) begin
                                fadr_d = rx_data[6:0];
                                endp_d = {endp_q[3:1], rx_data[7]};
                            end else begin
                                endp_d     = {rx_data[2:0], endp_q[0]};
                                frame_no_d = {rx_data[2:0], endp_q[0], fadr_q};
                            end
                        end
                    end
                    crc5_d    = crc5_n;
                    tok_cnt_d = cnt_n;
                    if (over) begin
                        seq_err_d = 1'b1;
                        state_d   = S_DROP;
                    end else if (!rx_active) begin
                        state_d = S_IDLE;
                        if (cnt_n == 2'd2) begin
                            if (crc5_n == 5'b01100) token_valid_d = 1'b1;
                            else                    crc5_err_d    = 1'b1;
                        end else begin
                            seq_err_d = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_err) begin
                    seq_err_d = 1'b1;
                    state_d   = S_DROP;
                end else begin
                    cnt_n = hcnt_q;
                    if (rx_valid) begin
                        crc16_n = usbf_crc16(crc16_q, rev8(rx_data));
                        if (hcnt_q == 2'd2) begin
                            if (size_q == 11'(MAX_PKT)) begin
                                over = 1'b1;
                            end else begin
                                data_st_d    = hold0_q;
                                data_valid_d = 1'b1;
                                size_d       = size_q + 11'd1;
                                hold0_d      = hold1_q;
                                hold1_d      = rx_data;
                            end
                        end else if (hcnt_q == 2'd1) begin
                            hold1_d = rx_data;
                            cnt_n   = 2'd2;
                        end else begin
                            hold0_d = rx_data;
                            cnt_n   = 2'd1;
                        end
                    end
                    crc16_d = crc16_n;
                    hcnt_d  = cnt_n;
                    if (over) begin
                        seq_err_d = 1'b1;
                        state_d   = S_DROP;
                    end else if (!rx_active) begin
                        data_done_d = 1'b1;
                        crc16_err_d = (crc16_n != 16'h800d) || (cnt_n != 2'd2);
                        state_d     = S_IDLE;
                    end
                end
            end
            S_HSHK: begin
                if (rx_err || rx_valid) begin
                    seq_err_d = 1'b1;
                    state_d   = S_DROP;
                end else if (!rx_active) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (!rx_active) begin
                    state_d = S_IDLE;
                    if (was_data_q) begin
                        data_done_d = 1'b1;
                        crc16_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rx_active_r_q <= 1'b1;
            pid_q         <= '0;
            pid_valid_q   <= 1'b0;
            pid_cks_err_q <= 1'b0;
            fadr_q        <= '0;
            endp_q        <= '0;
            frame_no_q    <= '0;
            token_valid_q <= 1'b0;
            crc5_err_q    <= 1'b0;
            data_st_q     <= '0;
            data_valid_q  <= 1'b0;
            data_done_q   <= 1'b0;
            crc16_err_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            size_q        <= '0;
            crc5_q        <= '1;
            crc16_q       <= '1;
            tok_cnt_q     <= '0;
            hcnt_q        <= '0;
            hold0_q       <= '0;
            hold1_q       <= '0;
            was_data_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_active_r_q <= rx_active_r_d;
            pid_q         <= pid_d;
            pid_valid_q   <= pid_valid_d;
            pid_cks_err_q <= pid_cks_err_d;
            fadr_q        <= fadr_d;
            endp_q        <= endp_d;
            frame_no_q    <= frame_no_d;
            token_valid_q <= token_valid_d;
            crc5_err_q    <= crc5_err_d;
            data_st_q     <= data_st_d;
            data_valid_q  <= data_valid_d;
            data_done_q   <= data_done_d;
            crc16_err_q   <= crc16_err_d;
            seq_err_q     <= seq_err_d;
            size_q        <= size_d;
            crc5_q        <= crc5_d;
            crc16_q       <= crc16_d;
            tok_cnt_q     <= tok_cnt_d;
            hcnt_q        <= hcnt_d;
            hold0_q       <= hold0_d;
            hold1_q       <= hold1_d;
            was_data_q    <= was_data_d;
        end
    end

    assign pid           = pid_q;
    assign pid_valid     = pid_valid_q;
    assign pid_cks_err   = pid_cks_err_q;
    assign token_fadr    = fadr_q;
    assign token_endp    = endp_q;
    assign frame_no      = frame_no_q;
    assign token_valid   = token_valid_q;
    assign crc5_err      = crc5_err_q;
    assign rx_data_st    = data_st_q;
    assign rx_data_valid = data_valid_q;
    assign rx_data_done  = data_done_q;
    assign crc16_err     = crc16_err_q;
    assign rx_size       = size_q;
    assign seq_err       = seq_err_q;

endmodule
